uart_tx: RTL
============

# uart_tx

UART transmitter that serialises one byte per request into a start / 8-data / optional-parity / stop frame on a single line. It is the stage directly upstream of `uart_rx`: its `tx_out` drives the receiver's serial input, and its frame format and bit period match that receiver. A simple start/busy/done handshake to the host logic sequences transmission, and a baud counter times each bit.

## Interface
- `CLKS_PER_BIT`, default 8: clock cycles per serial bit; legal range ≥ 2.
- `PARITY_EN`, default 1: 1 inserts a parity bit after the data bits; 0 omits it.
- `PARITY_ODD`, default 0: 0 selects even parity, 1 selects odd parity. Ignored when `PARITY_EN` = 0.
- `clock` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: one clock; reset is asynchronous and active-low (`reset` = 0 resets).
- `tx_start` input 1: transmit request, sampled only in IDLE.
- `tx_data` input 8: byte to send, captured on acceptance.
- `tx_out` output 1: serial line, idle high.
- `tx_busy` output 1: high while a frame is in progress.
- `tx_done` output 1: one-cycle pulse when a frame completes.

## Operation
- **States:** IDLE, START, DATA, PARITY, STOP.
- **Reset values:** state IDLE, `tx_out` = 1, `tx_busy` = 0, `tx_done` = 0, bit counter 0, baud counter 0, shift register 0.
- **IDLE:**
  - `tx_out` = 1.
  - If `tx_start` = 1, capture `tx_data` into the shift register, compute the parity bit, and go to START.
- **START:** `tx_out` = 0 for `CLKS_PER_BIT` cycles, then go to DATA.
- **DATA:**
  - `tx_out` = shift register bit 0, so bits go out LSB first.
  - After each `CLKS_PER_BIT` cycles, shift right and increment the 3-bit bit counter.
  - After bit 7, go to PARITY if `PARITY_EN` = 1, else to STOP.
- **PARITY:**
  - `tx_out` = XOR-reduce(captured data) XOR `PARITY_ODD`, held for `CLKS_PER_BIT` cycles.
  - Then go to STOP.
- **STOP:** `tx_out` = 1 for `CLKS_PER_BIT` cycles, then return to IDLE with `tx_done` = 1 for that single cycle.
- **Baud counter:**
  - Counts 0 to `CLKS_PER_BIT`−1.
  - Clears on every state transition and wraps at the end of each bit.
  - Width is clog2(`CLKS_PER_BIT`).
- **`tx_busy`:** 1 in START, DATA, PARITY and STOP; 0 in IDLE.
- **Data capture:** `tx_data` changes after acceptance have no effect on the frame in flight.
- **Requests while busy:** `tx_start` asserted while busy is ignored; requests are not queued.
- **Back-to-back frames:** `tx_start` high in the IDLE cycle where `tx_done` = 1 is accepted. With `tx_start` held high, frames therefore run continuously with one idle-high cycle between them.
- **Reset mid-frame:** the asynchronous assertion immediately forces all reset values, so `tx_out` returns high even partway through a bit. No `tx_done` pulse is produced for the aborted frame.

## Timing
- **Frame length:** N = (10 + `PARITY_EN`) × `CLKS_PER_BIT` cycles.
- **Acceptance:** `tx_start` = 1 is sampled in IDLE at rising edge k.
- **Start bit:** `tx_out` falls at edge k+1, and `tx_busy` rises at edge k+1. There is no combinational path from `tx_start` to `tx_out`.
- **Bit boundaries:** bit j of the frame (j = 0 is the start bit) occupies edges k+1+j·`CLKS_PER_BIT` through k+(j+1)·`CLKS_PER_BIT`.
- **Completion:** at edge k+1+N, `tx_done` = 1, `tx_busy` = 0 and state = IDLE. `tx_done` clears at the next edge.
- **Defaults (`CLKS_PER_BIT` = 8, parity on):**
  - Start bit at k+1..k+8.
  - Data bit i at k+9+8i..k+16+8i.
  - Parity at k+73..k+80.
  - Stop at k+81..k+88.
  - `tx_done` at k+89.
- **Registered outputs:** all outputs come straight from registers.

## Test plan
- **Single frame, defaults:** after reset release, pulse `tx_start` for 1 cycle with `tx_data` = 8'hED. Sampling `tx_out` mid-bit every 8 cycles must give 0, 1,0,1,1,0,1,1,1, parity 0, stop 1. `tx_done` must pulse exactly 89 cycles after acceptance.
- **Odd parity:** with `PARITY_ODD` = 1, send 8'hED and require a parity bit of 1. Send 8'h00 and require a parity bit of 1 (the even-parity value for 8'h00 is 0).
- **Parity disabled:** with `PARITY_EN` = 0, send 8'hA5. Require 10 bits (0, 1,0,1,0,0,1,0,1, 1) and `tx_done` at k+81.
- **Busy and data capture:** during the data bits of a frame for 8'h3C, pulse `tx_start` with `tx_data` = 8'hFF. The line must still carry 8'h3C, and no second frame may start.
- **Back-to-back:** hold `tx_start` high while sending 8'h55 then 8'hAA. The second start bit must begin one cycle after the `tx_done` pulse, and both frames must decode correctly.
- **Reset mid-frame:** assert `reset` = 0 at bit 4 of a frame. Require `tx_out` = 1, `tx_busy` = 0 and `tx_done` = 0 without waiting for a clock edge. After release, a fresh 8'h81 frame must transmit correctly.

Source files
------------

// File: rtl/uart_tx.sv
// UART transmitter: start / 8 data (LSB first) / optional parity / stop frame.
// Latency: start bit appears one cycle after acceptance; tx_done one cycle after the stop bit.
// Backpressure: tx_start is only honoured in IDLE; requests while busy are dropped, not queued.
module uart_tx #(
  parameter int CLKS_PER_BIT = 8,
  parameter int PARITY_EN    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx_out,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          parity_q, parity_d;
  logic          fin_q, fin_d;
  logic          tx_out_q, tx_out_d;
  logic          tx_busy_q, tx_busy_d;
  logic          tx_done_q, tx_done_d;
  logic          bit_end;

  // Last clock of the current serial bit.
  assign bit_end = (baud_q == BAUD_LAST);

  // State register; reset aborts any frame in flight.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: every transition out of a bit state happens on its last clock.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (tx_start) state_d = S_START;
      S_START:  if (bit_end) state_d = S_DATA;
      S_DATA:   if (bit_end && (bit_q == 3'd7)) state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
      S_PARITY: if (bit_end) state_d = S_STOP;
      S_STOP:   if (bit_end) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Output logic, decoded from the current state and registered below so the line lags state by one clock.
  always_comb begin
    tx_out_d  = 1'b1;
    tx_busy_d = (state_q != S_IDLE);
    fin_d     = (state_q == S_STOP) && bit_end;
    tx_done_d = fin_q;
    case (state_q)
      S_START:  tx_out_d = 1'b0;
      S_DATA:   tx_out_d = shift_q[0];
      S_PARITY: tx_out_d = parity_q;
      default:  tx_out_d = 1'b1;
    endcase
  end

  // Datapath next values: baud counter, bit index, shift register and captured parity.
  always_comb begin
    baud_d   = (state_q == S_IDLE || bit_end) ? '0 : baud_q + BW'(1);
    bit_d    = bit_q;
    shift_d  = shift_q;
    parity_d = parity_q;
    if (state_q == S_IDLE) begin
      bit_d = 3'd0;
      if (tx_start) begin
        shift_d  = tx_data;
        parity_d = (^tx_data) ^ (PARITY_ODD != 0);
      end
    end else if (state_q == S_DATA && bit_end) begin
      bit_d   = bit_q + 3'd1;
      shift_d = {1'b0, shift_q[7:1]};
    end
  end

  // Datapath and output registers; the line idles high out of reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      baud_q    <= '0;
      bit_q     <= 3'd0;
      shift_q   <= 8'd0;
      parity_q  <= 1'b0;
      fin_q     <= 1'b0;
      tx_out_q  <= 1'b1;
      tx_busy_q <= 1'b0;
      tx_done_q <= 1'b0;
    end else begin
      baud_q    <= baud_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
      fin_q     <= fin_d;
      tx_out_q  <= tx_out_d;
      tx_busy_q <= tx_busy_d;
      tx_done_q <= tx_done_d;
    end
  end

  assign tx_out  = tx_out_q;
  assign tx_busy = tx_busy_q;
  assign tx_done = tx_done_q;

endmodule
